ps2_keyboard: RTL and testbench
===============================

// Module: ps2_keyboard
// PURPOSE
//  - Upstream feeder of the Memory keyboard register: receives PS/2 scan-code set 2
//    frames from a physical keyboard and drives the 16-bit Hack keycode onto Memory.kbIn.
//  - kbOut holds the Hack code of the most recently pressed key while it is held.
//  - kbOut returns to 0 when that key is released, matching Hack KBD semantics.
// PARAMETERS
//  FRAME_TIMEOUT  50000  clk cycles without a ps2_clk falling edge mid-frame before abort
//  SYNC_STAGES    2      flip-flop depth of the ps2_clk/ps2_data synchronisers (>=2)
// PORTS
//  clk        in   1   system clock, 32 MHz; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  ps2_clk    in   1   PS/2 clock from keyboard, asynchronous
//  ps2_data   in   1   PS/2 data from keyboard, asynchronous
//  kbOut      out  16  Hack keycode; connects to Memory.kbIn
//  frame_err  out  1   one-cycle pulse on framing, parity or timeout error
// BEHAVIOUR
//  - Reset: kbOut=0, frame_err=0, FSM=IDLE, shift/brk/ext flags=0, last_sc=0, timeout cnt=0.
//  - Input sync: both inputs pass through SYNC_STAGES FFs.
//  - Edge detect: a falling edge is a synced ps2_clk 1->0 across consecutive clk cycles.
//  - Receive FSM, advancing only on falling edges:
//    IDLE  -> DATA    when data==0 (start bit); data==1 is ignored, stay in IDLE.
//    DATA  -> 8 bits, LSB first, into shift reg; -> PARITY after bit 7.
//    PARITY-> capture bit; -> STOP.
//    STOP  -> if data==1: byte_valid pulse next cycle. Else frame_err pulse, byte dropped.
//             Both cases -> IDLE.
//  - Timeout: in any non-IDLE state, the counter resets on each falling edge.
//    Counter reaching FRAME_TIMEOUT -> IDLE, frame_err pulse, partial byte dropped.
//  - Decoder (acts on byte_valid; kbOut updates the following cycle):
//    0xE0 -> ext=1. 0xF0 -> brk=1. Neither prefix changes kbOut.
//    Any other byte b, with key={ext,b}, clears ext and brk after processing:
//    * 0x12 or 0x59 (L/R shift): set or clear that shift flag per brk; kbOut unchanged.
//    * make, mapped: kbOut <= code; last_sc <= key.
//    * make, unmapped: no change.
//    * break with key==last_sc: kbOut <= 0. Break of any other key: no change (roll-over).
//  - Map, 16-bit zero-extended:
//    letters 'a'-'z' (0x61..) unshifted, 'A'-'Z' (0x41..) with either shift held.
//    digits 0-9 = 45,16,1E,26,25,2E,36,3D,3E,46 -> 0x30-0x39, shift ignored.
//    29 space -> 0x20; 5A enter -> 128; 66 backspace -> 129; 76 esc -> 140.
//    E0 6B -> 130 (left); E0 75 -> 131 (up); E0 74 -> 132 (right); E0 72 -> 133 (down).
//  - Simultaneous byte_valid and rst: rst wins.
//  - rst mid-frame: partial frame and all flags discarded.
//  - Latency: kbOut valid 2 clk after the falling edge that samples the stop bit.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined:
//    - Odd parity is checked in STOP.
//    - Mismatch -> frame_err pulse, byte dropped, no decode.
//  PS2_PARITY_CHECK_EN undefined:
//    - Parity bit is sampled and ignored.
//    - Only start, stop and timeout errors raise frame_err.
// TESTING  (PS/2 bit period 80 us; frames are otherwise well formed unless stated)
//  1 rst high 2 cycles, ps2 lines idle high -> kbOut==0x0000, frame_err==0 throughout.
//  2 Send 1C; then F0,1C -> kbOut 0x0061 after 1C; 0x0000 after second 1C.
//  3 Send 12, 1C -> kbOut 0x0000 after 12, 0x0041 after 1C.
//    Then F0,1C, F0,12, then 1C -> 0x0000, then 0x0061.
//  4 Send E0,75 -> kbOut 0x0083. Send E0,F0,75 -> kbOut 0x0000.
//  5 Roll-over: send 1C, 32, F0,1C, F0,32 -> kbOut 0x61, 0x62, 0x62, 0x0000.
//  6 Errors:
//    - stop bit 0 on byte 1C -> one-cycle frame_err, kbOut unchanged.
//    - 5 bits then idle FRAME_TIMEOUT+1 clk -> frame_err; next good 29 -> 0x0020.
//    - bad parity on 1C -> dropped + frame_err with PS2_PARITY_CHECK_EN;
//      kbOut 0x0061 without it.

Source files
------------

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 set-2 receiver feeding Hack keycodes to Memory.kbIn (odd parity check when PS2_PARITY_CHECK_EN is defined)
module ps2_keyboard #(
    parameter int FRAME_TIMEOUT = 50000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kbOut,
    output logic        frame_err
);
    localparam int CW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [CW-1:0] TO = CW'(FRAME_TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t state, next_state;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic clk_s, data_s, clk_prev, fall, timeout, par_ok, byte_ok, err, byte_valid;
    logic [2:0] bit_cnt;
    logic [7:0] shreg, code;
    logic [CW-1:0] cnt;
    logic ext, brk, lshift, rshift;
    logic [8:0] key, last_sc;

    assign clk_s   = clk_sync[SYNC_STAGES-1];
    assign data_s  = data_sync[SYNC_STAGES-1];
    assign fall    = clk_prev & ~clk_s;
    assign timeout = (state != IDLE) && !fall && (cnt == TO);
    assign key     = {ext, shreg};
    assign code    = keymap(key, lshift | rshift);

`ifdef PS2_PARITY_CHECK_EN
    logic par;
    assign par_ok = ^{shreg, par};
`else
    assign par_ok = 1'b1;
`endif

    // Scan code (with extended flag) to Hack code; 0 means unmapped
    function automatic logic [7:0] keymap(input logic [8:0] k, input logic sh);
        logic [7:0] r;
        case (k)
            9'h01C: r = 8'h61;
            9'h032: r = 8'h62;
            9'h021: r = 8'h63;
            9'h023: r = 8'h64;
            9'h024: r = 8'h65;
            9'h02B: r = 8'h66;
            9'h034: r = 8'h67;
            9'h033: r = 8'h68;
            9'h043: r = 8'h69;
            9'h03B: r = 8'h6A;
            9'h042: r = 8'h6B;
            9'h04B: r = 8'h6C;
            9'h03A: r = 8'h6D;
            9'h031: r = 8'h6E;
            9'h044: r = 8'h6F;
            9'h04D: r = 8'h70;
            9'h015: r = 8'h71;
            9'h02D: r = 8'h72;
            9'h01B: r = 8'h73;
            9'h02C: r = 8'h74;
            9'h03C: r = 8'h75;
            9'h02A: r = 8'h76;
            9'h01D: r = 8'h77;
            9'h022: r = 8'h78;
            9'h035: r = 8'h79;
            9'h01A: r = 8'h7A;
            9'h045: r = 8'h30;
            9'h016: r = 8'h31;
            9'h01E: r = 8'h32;
            9'h026: r = 8'h33;
            9'h025: r = 8'h34;
            9'h02E: r = 8'h35;
            9'h036: r = 8'h36;
            9'h03D: r = 8'h37;
            9'h03E: r = 8'h38;
            9'h046: r = 8'h39;
            9'h029: r = 8'h20;
            9'h05A: r = 8'd128;
            9'h066: r = 8'd129;
            9'h076: r = 8'd140;
            9'h16B: r = 8'd130;
            9'h175: r = 8'd131;
            9'h174: r = 8'd132;
            9'h172: r = 8'd133;
            default: r = 8'h00;
        endcase
        return (sh && r >= 8'h61 && r <= 8'h7A) ? r - 8'h20 : r;
    endfunction

    // Synchronise the asynchronous PS/2 lines; idle-high reset avoids a false edge
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    // Receive FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state: advance on PS/2 falling edges, abort on timeout
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (fall && !data_s) next_state = DATA;
            DATA:   if (fall && bit_cnt == 3'd7) next_state = PARITY;
            PARITY: if (fall) next_state = STOP;
            STOP:   if (fall) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (timeout) next_state = IDLE;
    end

    // FSM outputs: good byte at a valid stop bit, error on bad stop/parity or timeout
    always_comb begin
        byte_ok = (state == STOP) && fall && data_s && par_ok;
        err     = ((state == STOP) && fall && !(data_s && par_ok)) || timeout;
    end

    // Frame datapath: bit shifting, timeout counter and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            cnt        <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par        <= 1'b0;
`endif
        end else begin
            byte_valid <= byte_ok;
            frame_err  <= err;
            cnt        <= (state == IDLE || fall) ? '0 : cnt + 1'b1;
            if (fall && state == IDLE) bit_cnt <= '0;
            if (fall && state == DATA) begin
                shreg   <= {data_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
`ifdef PS2_PARITY_CHECK_EN
            if (fall && state == PARITY) par <= data_s;
`endif
        end
    end

    // Decoder: track prefixes and shift, hold the last pressed key's code until its release
    always_ff @(posedge clk) begin
        if (rst) begin
            kbOut   <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            lshift  <= 1'b0;
            rshift  <= 1'b0;
            last_sc <= '0;
        end else if (byte_valid) begin
            if (shreg == 8'hE0) ext <= 1'b1;
            else if (shreg == 8'hF0) brk <= 1'b1;
            else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (key == 9'h012) lshift <= ~brk;
                else if (key == 9'h059) rshift <= ~brk;
                else if (brk) begin
                    if (key == last_sc) kbOut <= '0;
                end else if (code != 8'h00) begin
                    kbOut   <= {8'h00, code};
                    last_sc <= key;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed PS/2 frame sequences checked with immediate assertions
module tb_ps2_keyboard;
    localparam int H  = 8;
    localparam int TO = 200;

    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [15:0] kbOut;
    logic frame_err;
    int checks = 0, failures = 0, err_cnt = 0, e0;

    ps2_keyboard #(.FRAME_TIMEOUT(TO), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kbOut(kbOut), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count every cycle frame_err is high so a stuck pulse shows as >1
    always @(posedge clk) if (frame_err === 1'b1) err_cnt <= err_cnt + 1;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Send the first nbits of a frame: start, 8 data LSB first, odd parity, stop
    task automatic send(input logic [7:0] b, input logic stop = 1'b1,
                        input logic flip = 1'b0, input int nbits = 11);
        logic [10:0] bits;
        bits = {stop, ~^b ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_clk(H);
            ps2_clk = 1'b0;
            wait_clk(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_clk(20);
    endtask

    initial begin
        wait_clk(2);
        rst = 1'b0;
        wait_clk(5);
        check("reset_kb", kbOut, 16'h0000);
        check("reset_err", 16'(err_cnt), 16'd0);

        send(8'h1C);                check("a_make", kbOut, 16'h0061);
        send(8'hF0);                check("f0_hold", kbOut, 16'h0061);
        send(8'h1C);                check("a_break", kbOut, 16'h0000);

        send(8'h12);                check("lshift_make", kbOut, 16'h0000);
        send(8'h1C);                check("A_shift", kbOut, 16'h0041);
        send(8'hF0); send(8'h1C);   check("A_break", kbOut, 16'h0000);
        send(8'hF0); send(8'h12);   check("lshift_break", kbOut, 16'h0000);
        send(8'h1C);                check("a_unshift", kbOut, 16'h0061);
        send(8'hF0); send(8'h1C);

        send(8'hE0); send(8'h75);   check("up_make", kbOut, 16'h0083);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_break", kbOut, 16'h0000);

        send(8'h1C);                check("roll_a", kbOut, 16'h0061);
        send(8'h32);                check("roll_b", kbOut, 16'h0062);
        send(8'hF0); send(8'h1C);   check("roll_a_rel", kbOut, 16'h0062);
        send(8'hF0); send(8'h32);   check("roll_b_rel", kbOut, 16'h0000);

        e0 = err_cnt;
        send(8'h1C, 1'b0);
        check("stop_err_cnt", 16'(err_cnt - e0), 16'd1);
        check("stop_err_kb", kbOut, 16'h0000);

        e0 = err_cnt;
        send(8'h1C, 1'b1, 1'b0, 5);
        wait_clk(TO + 50);
        check("timeout_err", 16'(err_cnt - e0), 16'd1);
        check("timeout_kb", kbOut, 16'h0000);
        send(8'h29);                check("space", kbOut, 16'h0020);

        e0 = err_cnt;
        send(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("par_kb", kbOut, 16'h0020);
        check("par_err", 16'(err_cnt - e0), 16'd1);
`else
        check("par_kb", kbOut, 16'h0061);
        check("par_err", 16'(err_cnt - e0), 16'd0);
`endif

        send(8'h59); send(8'h1C);   check("A_rshift", kbOut, 16'h0041);
        send(8'hF0); send(8'h59);
        send(8'h45);                check("digit0", kbOut, 16'h0030);
        send(8'h5A);                check("enter", kbOut, 16'd128);
        send(8'h66);                check("bksp", kbOut, 16'd129);
        send(8'h76);                check("esc", kbOut, 16'd140);
        send(8'hE0); send(8'h6B);   check("left", kbOut, 16'd130);
        send(8'hE0); send(8'h74);   check("right", kbOut, 16'd132);
        send(8'hE0); send(8'h72);   check("down", kbOut, 16'd133);
        send(8'h05);                check("unmapped", kbOut, 16'd133);
        send(8'hF0); send(8'h1C);   check("other_rel", kbOut, 16'd133);
        send(8'hE0); send(8'hF0); send(8'h72);
        check("down_rel", kbOut, 16'h0000);

        send(8'h12); send(8'h1C);   check("pre_rst", kbOut, 16'h0041);
        send(8'h32, 1'b1, 1'b0, 5);
        e0 = err_cnt;
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        check("midrst_kb", kbOut, 16'h0000);
        wait_clk(TO + 50);
        check("midrst_noerr", 16'(err_cnt - e0), 16'd0);
        send(8'h1C);                check("post_rst", kbOut, 16'h0061);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
